// File: rtl/mem_common_pkg.sv
// Shared memory-side types for the instruction-fetch miss path.
// Holds the physical address and line-data types, the miss-queue entry states and line alignment.
package mem_common_pkg;

   localparam int unsigned MC_PADDR_W    = 32;
   localparam int unsigned MC_LINE_BYTES = 64;

   typedef logic [MC_PADDR_W-1:0]      t_paddr;
   typedef logic [MC_LINE_BYTES*8-1:0] t_line_data;

   typedef enum logic [1:0] {
      MQ_IDLE = 2'd0,
      MQ_REQ  = 2'd1,
      MQ_WAIT = 2'd2,
      MQ_FILL = 2'd3
   } t_mq_state;

   // Clear the byte-offset bits so the address names a whole line.
   function automatic t_paddr line_align(input t_paddr a);
      return a & ~t_paddr'(MC_LINE_BYTES - 1);
   endfunction

endpackage

// File: rtl/ic_mq_entry.sv
// One outstanding line miss: the lifecycle state, the line address, the captured data and the drop bit.
// The parent module chooses which entry is allocated, issued or filled in each cycle.
module ic_mq_entry
   import mem_common_pkg::*;
#(
   parameter int unsigned DATA_W = MC_LINE_BYTES * 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_alloc,
   input  t_paddr            i_alloc_addr,
   input  t_paddr            i_line,
   input  logic              i_req_ack,
   input  logic              i_rsp,
   input  logic [DATA_W-1:0] i_rsp_data,
   input  logic              i_fill_take,
   input  logic              i_flush,
   output t_mq_state         o_state,
   output t_paddr            o_addr,
   output logic [DATA_W-1:0] o_data,
   output logic              o_drop,
   output logic              o_match_c
);

   t_mq_state         r_state;
   t_paddr            r_addr;
   logic [DATA_W-1:0] r_data;
   logic              r_drop;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= MQ_IDLE;
         r_addr  <= '0;
         r_data  <= '0;
         r_drop  <= 1'b0;
      end else begin
         case (r_state)
            MQ_IDLE: begin
               if (i_alloc) begin
                  r_state <= MQ_REQ;
                  r_addr  <= i_alloc_addr;
                  r_drop  <= 1'b0;
               end
            end
            // A flush withdraws an unissued request unless it is accepted in the same cycle.
            MQ_REQ: begin
               if (i_req_ack) begin
                  r_state <= MQ_WAIT;
                  r_drop  <= i_flush;
               end else if (i_flush) begin
                  r_state <= MQ_IDLE;
               end
            end
            MQ_WAIT: begin
               if (i_rsp) begin
                  r_state <= MQ_FILL;
                  r_data  <= i_rsp_data;
               end
               if (i_flush) begin
                  r_drop <= 1'b1;
               end
            end
            MQ_FILL: begin
               if (i_fill_take) begin
                  r_state <= MQ_IDLE;
                  r_drop  <= 1'b0;
               end else if (i_flush) begin
                  r_drop <= 1'b1;
               end
            end
            default: r_state <= MQ_IDLE;
         endcase
      end
   end

   assign o_state   = r_state;
   assign o_addr    = r_addr;
   assign o_data    = r_data;
   assign o_drop    = r_drop;
   assign o_match_c = (r_state != MQ_IDLE) && !r_drop && (r_addr == i_line);

endmodule

// File: rtl/ic_miss_queue.sv
// Icache miss queue: merges duplicate line misses and issues one tagged memory read per line.
// Fills return to the icache in the order responses arrive, and a flush can cancel delivery.
module ic_miss_queue
   import mem_common_pkg::*;
#(
   parameter int unsigned NUM_ENTS   = 4,
   parameter int unsigned LINE_BYTES = MC_LINE_BYTES,
   parameter int unsigned ID_W       = $clog2(NUM_ENTS)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    miss_vld,
   input  t_paddr                  miss_addr,
   output logic                    miss_rdy,
   input  logic                    flush,
   output logic                    mem_req_vld,
   output t_paddr                  mem_req_addr,
   output logic [ID_W-1:0]         mem_req_id,
   input  logic                    mem_req_rdy,
   input  logic                    mem_rsp_vld,
   input  logic [ID_W-1:0]         mem_rsp_id,
   input  logic [LINE_BYTES*8-1:0] mem_rsp_data,
   output logic                    fill_vld,
   output t_paddr                  fill_addr,
   output logic [LINE_BYTES*8-1:0] fill_data
);

   localparam int unsigned DATA_W = LINE_BYTES * 8;

   t_mq_state         w_state [NUM_ENTS];
   t_paddr            w_addr  [NUM_ENTS];
   logic [DATA_W-1:0] w_data  [NUM_ENTS];
   logic [NUM_ENTS-1:0] w_drop;
   logic [NUM_ENTS-1:0] w_match;

   t_paddr          w_line;
   logic            w_any_idle;
   logic [ID_W-1:0] w_alloc_idx;
   logic            w_req_hit;
   logic [ID_W-1:0] w_req_idx;
   logic            w_fill_hit;
   logic [ID_W-1:0] w_fill_idx;
   logic            w_any_match;
   logic            w_take;
   logic            w_req_fire;
   logic            w_fill_ok;

   logic              r_live;
   logic              r_fill_vld;
   t_paddr            r_fill_addr;
   logic [DATA_W-1:0] r_fill_data;

   assign w_line = line_align(miss_addr);

   // Lowest-index pick for allocation, request issue and fill; scanning downward leaves the lowest hit.
   always_comb begin
      w_any_idle  = 1'b0;
      w_alloc_idx = '0;
      w_req_hit   = 1'b0;
      w_req_idx   = '0;
      w_fill_hit  = 1'b0;
      w_fill_idx  = '0;
      for (int i = NUM_ENTS - 1; i >= 0; i--) begin
         if (w_state[i] == MQ_IDLE) begin
            w_any_idle  = 1'b1;
            w_alloc_idx = ID_W'(i);
         end
         if (w_state[i] == MQ_REQ) begin
            w_req_hit = 1'b1;
            w_req_idx = ID_W'(i);
         end
         if (w_state[i] == MQ_FILL) begin
            w_fill_hit = 1'b1;
            w_fill_idx = ID_W'(i);
         end
      end
   end

   assign w_any_match = |w_match;
   assign miss_rdy    = r_live && w_any_idle;
   assign w_take      = miss_vld && miss_rdy && !flush && !w_any_match;

   assign mem_req_vld  = w_req_hit;
   assign mem_req_addr = w_req_hit ? w_addr[w_req_idx] : '0;
   assign mem_req_id   = w_req_idx;
   assign w_req_fire   = w_req_hit && mem_req_rdy;

   for (genvar g = 0; g < NUM_ENTS; g++) begin : g_ent
      ic_mq_entry #(
         .DATA_W (DATA_W)
      ) u_ent (
         .clk          (clk),
         .reset        (reset),
         .i_alloc      (w_take && (w_alloc_idx == ID_W'(g))),
         .i_alloc_addr (w_line),
         .i_line       (w_line),
         .i_req_ack    (w_req_fire && (w_req_idx == ID_W'(g))),
         .i_rsp        (mem_rsp_vld && (mem_rsp_id == ID_W'(g))),
         .i_rsp_data   (mem_rsp_data),
         .i_fill_take  (w_fill_hit && (w_fill_idx == ID_W'(g))),
         .i_flush      (flush),
         .o_state      (w_state[g]),
         .o_addr       (w_addr[g]),
         .o_data       (w_data[g]),
         .o_drop       (w_drop[g]),
         .o_match_c    (w_match[g])
      );
   end

   // Holds miss_rdy low until the first clock edge after reset releases.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_live <= 1'b0;
      end else begin
         r_live <= 1'b1;
      end
   end

   // Dropped entries and the flush cycle retire the selected fill silently.
   assign w_fill_ok = w_fill_hit && !w_drop[w_fill_idx] && !flush;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_fill_vld  <= 1'b0;
         r_fill_addr <= '0;
         r_fill_data <= '0;
      end else begin
         r_fill_vld <= w_fill_ok;
         if (w_fill_ok) begin
            r_fill_addr <= w_addr[w_fill_idx];
            r_fill_data <= w_data[w_fill_idx];
         end
      end
   end

   assign fill_vld  = r_fill_vld;
   assign fill_addr = r_fill_addr;
   assign fill_data = r_fill_data;

   // Memory may only answer a request that is still outstanding.
   always_ff @(posedge clk) begin
      if (mem_rsp_vld) begin
         a_rsp_to_wait: assert (w_state[mem_rsp_id] == MQ_WAIT);
      end
   end

endmodule

// File: tb/tb_ic_miss_queue.sv
// Directed bench for ic_miss_queue: every step drives inputs just after a rising edge and checks
// hand-computed outputs at the same point, covering merge, backpressure, reordering, flush and reset.
module tb_ic_miss_queue;
   import mem_common_pkg::*;

   localparam int unsigned NUM_ENTS   = 4;
   localparam int unsigned LINE_BYTES = 64;
   localparam int unsigned ID_W       = 2;

   localparam logic [511:0] D1  = {16{32'hD1D1_0001}};
   localparam logic [511:0] D2  = {16{32'hD2D2_0002}};
   localparam logic [511:0] D3  = {16{32'hD3D3_0003}};
   localparam logic [511:0] D40 = {16{32'h4040_0000}};
   localparam logic [511:0] D41 = {16{32'h4141_0001}};
   localparam logic [511:0] D5  = {16{32'h5555_0005}};
   localparam logic [511:0] D6  = {16{32'h6666_0006}};
   localparam logic [511:0] D7  = {16{32'h7777_0007}};
   localparam logic [511:0] D8  = {16{32'h8888_0008}};

   logic                    clk;
   logic                    reset;
   logic                    miss_vld;
   t_paddr                  miss_addr;
   logic                    miss_rdy;
   logic                    flush;
   logic                    mem_req_vld;
   t_paddr                  mem_req_addr;
   logic [ID_W-1:0]         mem_req_id;
   logic                    mem_req_rdy;
   logic                    mem_rsp_vld;
   logic [ID_W-1:0]         mem_rsp_id;
   logic [LINE_BYTES*8-1:0] mem_rsp_data;
   logic                    fill_vld;
   t_paddr                  fill_addr;
   logic [LINE_BYTES*8-1:0] fill_data;

   int checks = 0;
   int errors = 0;

   ic_miss_queue #(
      .NUM_ENTS   (NUM_ENTS),
      .LINE_BYTES (LINE_BYTES),
      .ID_W       (ID_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .miss_vld     (miss_vld),
      .miss_addr    (miss_addr),
      .miss_rdy     (miss_rdy),
      .flush        (flush),
      .mem_req_vld  (mem_req_vld),
      .mem_req_addr (mem_req_addr),
      .mem_req_id   (mem_req_id),
      .mem_req_rdy  (mem_req_rdy),
      .mem_rsp_vld  (mem_rsp_vld),
      .mem_rsp_id   (mem_rsp_id),
      .mem_rsp_data (mem_rsp_data),
      .fill_vld     (fill_vld),
      .fill_addr    (fill_addr),
      .fill_data    (fill_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic miss(input logic v, input t_paddr a);
      miss_vld  = v;
      miss_addr = a;
   endtask

   task automatic rsp(input logic v, input logic [ID_W-1:0] id, input logic [511:0] d);
      mem_rsp_vld  = v;
      mem_rsp_id   = id;
      mem_rsp_data = d;
   endtask

   initial begin
      reset = 1'b0;
      miss(1'b0, '0);
      flush       = 1'b0;
      mem_req_rdy = 1'b0;
      rsp(1'b0, '0, '0);

      // Reset state
      #12;
      chk("rst_miss_rdy", miss_rdy, 0);
      chk("rst_req_vld", mem_req_vld, 0);
      chk("rst_req_addr", mem_req_addr, 0);
      chk("rst_fill_vld", fill_vld, 0);
      @(negedge clk);
      reset = 1'b1;
      tick();
      chk("post_rst_miss_rdy", miss_rdy, 1);

      // Single miss 0x1234
      miss(1'b1, 32'h1234); mem_req_rdy = 1'b1;
      tick();
      miss(1'b0, '0);
      chk("t1_req_vld", mem_req_vld, 1);
      chk("t1_req_addr", mem_req_addr, 32'h1200);
      chk("t1_req_id", mem_req_id, 0);
      chk("t1_miss_rdy", miss_rdy, 1);
      tick();
      mem_req_rdy = 1'b0;
      chk("t1_req_done", mem_req_vld, 0);
      tick();
      rsp(1'b1, 2'd0, D1);
      tick();
      rsp(1'b0, '0, '0);
      chk("t1_no_early_fill", fill_vld, 0);
      tick();
      chk("t1_fill_vld", fill_vld, 1);
      chk("t1_fill_addr", fill_addr, 32'h1200);
      chk("t1_fill_data", fill_data, D1);
      chk("t1_miss_rdy_end", miss_rdy, 1);
      tick();
      chk("t1_fill_one", fill_vld, 0);

      // Duplicate misses merge into one request
      miss(1'b1, 32'h1000);
      tick();
      miss(1'b1, 32'h1010);
      tick();
      miss(1'b1, 32'h1020);
      tick();
      miss(1'b0, '0);
      chk("t2_req_addr", mem_req_addr, 32'h1000);
      chk("t2_req_id", mem_req_id, 0);
      mem_req_rdy = 1'b1;
      tick();
      mem_req_rdy = 1'b0;
      chk("t2_single_req", mem_req_vld, 0);
      rsp(1'b1, 2'd0, D2);
      tick();
      rsp(1'b0, '0, '0);
      tick();
      chk("t2_fill_vld", fill_vld, 1);
      chk("t2_fill_addr", fill_addr, 32'h1000);
      chk("t2_fill_data", fill_data, D2);
      tick();
      chk("t2_single_fill", fill_vld, 0);

      // Queue full: fifth miss waits for a free entry
      miss(1'b1, 32'h0);
      tick();
      miss(1'b1, 32'h40);
      tick();
      miss(1'b1, 32'h80);
      tick();
      miss(1'b1, 32'hC0);
      tick();
      chk("t3_full", miss_rdy, 0);
      chk("t3_req_addr0", mem_req_addr, 32'h0);
      miss(1'b1, 32'h100); mem_req_rdy = 1'b1;
      tick();
      mem_req_rdy = 1'b0;
      chk("t3_req_id1", mem_req_id, 1);
      chk("t3_req_addr1", mem_req_addr, 32'h40);
      chk("t3_still_full", miss_rdy, 0);
      rsp(1'b1, 2'd0, D3);
      tick();
      rsp(1'b0, '0, '0);
      chk("t3_full_in_fill", miss_rdy, 0);
      tick();
      chk("t3_fill_vld", fill_vld, 1);
      chk("t3_fill_addr", fill_addr, 32'h0);
      chk("t3_fill_data", fill_data, D3);
      chk("t3_rdy_freed", miss_rdy, 1);
      tick();
      miss(1'b0, '0);
      chk("t3_full_again", miss_rdy, 0);
      chk("t3_req_new", mem_req_addr, 32'h100);
      chk("t3_req_new_id", mem_req_id, 0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t3_flush_rdy", miss_rdy, 1);
      chk("t3_flush_req", mem_req_vld, 0);

      // Out-of-order responses
      miss(1'b1, 32'h0); mem_req_rdy = 1'b1;
      tick();
      miss(1'b1, 32'h40);
      chk("t4_req_id0", mem_req_id, 0);
      tick();
      miss(1'b0, '0);
      chk("t4_req_id1", mem_req_id, 1);
      chk("t4_req_addr1", mem_req_addr, 32'h40);
      tick();
      mem_req_rdy = 1'b0;
      chk("t4_reqs_done", mem_req_vld, 0);
      rsp(1'b1, 2'd1, D41);
      tick();
      rsp(1'b1, 2'd0, D40);
      tick();
      rsp(1'b0, '0, '0);
      chk("t4_fill1_vld", fill_vld, 1);
      chk("t4_fill1_addr", fill_addr, 32'h40);
      chk("t4_fill1_data", fill_data, D41);
      tick();
      chk("t4_fill0_vld", fill_vld, 1);
      chk("t4_fill0_addr", fill_addr, 32'h0);
      chk("t4_fill0_data", fill_data, D40);
      tick();
      chk("t4_fill_end", fill_vld, 0);

      // Flush with id0 waiting and id1 requesting
      miss(1'b1, 32'h0); mem_req_rdy = 1'b1;
      tick();
      miss(1'b1, 32'h40);
      tick();
      miss(1'b0, '0); mem_req_rdy = 1'b0;
      chk("t5_req_id1", mem_req_id, 1);
      chk("t5_req_vld", mem_req_vld, 1);
      flush = 1'b1; miss(1'b1, 32'h80);
      tick();
      flush = 1'b0; miss(1'b1, 32'h0);
      chk("t5_req_cancel", mem_req_vld, 0);
      chk("t5_rdy", miss_rdy, 1);
      tick();
      miss(1'b0, '0);
      chk("t5_fresh_vld", mem_req_vld, 1);
      chk("t5_fresh_id", mem_req_id, 1);
      chk("t5_fresh_addr", mem_req_addr, 32'h0);
      mem_req_rdy = 1'b1;
      rsp(1'b1, 2'd0, D5);
      tick();
      mem_req_rdy = 1'b0;
      chk("t5_fresh_sent", mem_req_vld, 0);
      rsp(1'b1, 2'd1, D6);
      tick();
      rsp(1'b0, '0, '0);
      chk("t5_drop_no_fill", fill_vld, 0);
      tick();
      chk("t5_fill_vld", fill_vld, 1);
      chk("t5_fill_addr", fill_addr, 32'h0);
      chk("t5_fill_data", fill_data, D6);
      tick();
      chk("t5_fill_end", fill_vld, 0);

      // Reset while entries are outstanding
      miss(1'b1, 32'h200); mem_req_rdy = 1'b1;
      tick();
      miss(1'b1, 32'h240);
      tick();
      miss(1'b0, '0);
      tick();
      mem_req_rdy = 1'b0;
      chk("t6_both_wait", mem_req_vld, 0);
      rsp(1'b1, 2'd0, D7);
      tick();
      rsp(1'b0, '0, '0);
      tick();
      chk("t6_fill_before", fill_vld, 1);
      chk("t6_fill_addr", fill_addr, 32'h200);
      #2;
      reset = 1'b0;
      #1;
      chk("t6_rst_fill_vld", fill_vld, 0);
      chk("t6_rst_fill_addr", fill_addr, 0);
      chk("t6_rst_fill_data", fill_data, 0);
      chk("t6_rst_req_vld", mem_req_vld, 0);
      chk("t6_rst_miss_rdy", miss_rdy, 0);
      tick();
      tick();
      @(negedge clk);
      reset = 1'b1;
      tick();
      chk("t6_rel_miss_rdy", miss_rdy, 1);
      chk("t6_rel_req_vld", mem_req_vld, 0);
      chk("t6_rel_fill_vld", fill_vld, 0);
      tick();
      chk("t6_no_stale_fill", fill_vld, 0);

      // Flush in the cycle a fill is selected suppresses it
      miss(1'b1, 32'h300); mem_req_rdy = 1'b1;
      tick();
      miss(1'b0, '0);
      tick();
      mem_req_rdy = 1'b0;
      rsp(1'b1, 2'd0, D8);
      tick();
      rsp(1'b0, '0, '0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t7_fill_suppressed", fill_vld, 0);
      chk("t7_rdy", miss_rdy, 1);
      chk("t7_req_vld", mem_req_vld, 0);
      tick();
      chk("t7_no_late_fill", fill_vld, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
